// File: rtl/win_check_pkg.sv
// Shared constants and enums for the gomoku win-check scheduler.
// Board geometry, reach limits, direction and FSM state encodings.
package win_check_pkg;

  localparam int BOARD_DIM = 16;
  localparam int MAX_REACH = 4;
  localparam int WIN_LEN   = 5;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    DONE
  } state_e;

  // min(a, b) clamped to the reach limit
  function automatic logic [3:0] reach(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] m;
    m = (a < b) ? a : b;
    return (m > 4'(MAX_REACH)) ? 4'(MAX_REACH) : m;
  endfunction

endpackage

// File: rtl/win_check_scheduler_line_scan_unit.sv
// line_scan_unit: walks one direction's window, issues reads, counts run.
// Ports: load/active from FSM, dir/pointer/chess, rd_* memory, hit/last status.
module line_scan_unit
  import win_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       active,
  input  dir_e       dir,
  input  logic [7:0] pointer,
  input  logic [1:0] chess,
  input  logic [1:0] rd_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  output logic       hit,
  output logic       last
);

  localparam logic [3:0] EDGE = 4'(BOARD_DIM - 1);

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] nrow;
  logic [3:0] ncol;
  logic [3:0] back;
  logic [3:0] fwd;
  logic [3:0] len;
  logic [3:0] first_row;
  logic [3:0] first_col;
  logic [3:0] step_row;
  logic [3:0] step_col;

  logic [3:0] cur_row;
  logic [3:0] cur_col;
  logic [3:0] rem;
  logic       valid;
  logic [2:0] run;
  logic       match;

  assign row  = pointer[7:4];
  assign col  = pointer[3:0];
  assign nrow = EDGE - row;
  assign ncol = EDGE - col;

  // Reach is bounded by the edge, so first cell never wraps.
  always_comb begin
    back      = 4'd0;
    fwd       = 4'd0;
    first_row = row;
    first_col = col;
    unique case (dir)
      DIR_H: begin
        back      = reach(col, col);
        fwd       = reach(ncol, ncol);
        first_col = col - back;
      end
      DIR_V: begin
        back      = reach(row, row);
        fwd       = reach(nrow, nrow);
        first_row = row - back;
      end
      DIR_D: begin
        back      = reach(row, col);
        fwd       = reach(nrow, ncol);
        first_row = row - back;
        first_col = col - back;
      end
      DIR_A: begin
        back      = reach(nrow, col);
        fwd       = reach(row, ncol);
        first_row = row + back;
        first_col = col - back;
      end
    endcase
  end

  assign len = back + fwd + 4'd1;

  always_comb begin
    step_row = cur_row;
    step_col = cur_col;
    unique case (dir)
      DIR_H: step_col = cur_col + 4'd1;
      DIR_V: step_row = cur_row + 4'd1;
      DIR_D: begin
        step_row = cur_row + 4'd1;
        step_col = cur_col + 4'd1;
      end
      DIR_A: begin
        step_row = cur_row - 4'd1;
        step_col = cur_col + 4'd1;
      end
    endcase
  end

  assign rd_en   = active && (rem != 4'd0);
  assign last    = active && (rem == 4'd0);
  assign rd_addr = {cur_row, cur_col};
  assign match   = valid && (rd_data == chess);
  assign hit     = active && match && (run >= 3'(WIN_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row <= 4'd0;
      cur_col <= 4'd0;
      rem     <= 4'd0;
      valid   <= 1'b0;
      run     <= 3'd0;
    end else if (load) begin
      cur_row <= first_row;
      cur_col <= first_col;
      rem     <= len;
      valid   <= 1'b0;
      run     <= 3'd0;
    end else if (active) begin
      valid <= rd_en;
      if (rd_en) begin
        rem <= rem - 4'd1;
        // hold on the last cell so the address stays on the board
        if (rem != 4'd1) begin
          cur_row <= step_row;
          cur_col <= step_col;
        end
      end
      if (valid) begin
        if (rd_data == chess) begin
          if (run != 3'(WIN_LEN))
            run <= run + 3'd1;
        end else begin
          run <= 3'd0;
        end
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/win_check_scheduler.sv
// Win-check scheduler: scans the 4 lines through the last move for 5-in-a-row.
// Ports: start/pointer/chess request, rd_* board memory, busy/done/win/win_dir.
module win_check_scheduler
  import win_check_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] pointer,
  input  logic [1:0] chess,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic [1:0] win_dir
);

  state_e     state_q;
  state_e     state_d;
  dir_e       dir_q;
  dir_e       win_dir_q;
  logic [7:0] ptr_q;
  logic [1:0] color_q;
  logic       win_q;
  logic       accept;
  logic       hit;
  logic       last;

  assign accept  = (state_q == IDLE) && start;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign win     = win_q;
  assign win_dir = win_dir_q;

  line_scan_unit u_scan (
    .clk     (clk),
    .rst_n   (reset_n),
    .load    (state_q == SETUP),
    .active  (state_q == SCAN),
    .dir     (dir_q),
    .pointer (ptr_q),
    .chess   (color_q),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .hit     (hit),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (chess == 2'd0) ? DONE : SETUP;
      end
      SETUP: state_d = SCAN;
      SCAN: begin
        if (hit)
          state_d = DONE;
        else if (last)
          state_d = (dir_q == DIR_A) ? DONE : SETUP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dir_q     <= DIR_H;
      ptr_q     <= 8'd0;
      color_q   <= 2'd0;
      win_q     <= 1'b0;
      win_dir_q <= DIR_H;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q     <= pointer;
        color_q   <= chess;
        dir_q     <= DIR_H;
        win_q     <= 1'b0;
        win_dir_q <= DIR_H;
      end
      if (state_q == SCAN) begin
        if (hit) begin
          win_q     <= 1'b1;
          win_dir_q <= dir_q;
        end else if (last && dir_q != DIR_A) begin
          dir_q <= dir_e'(dir_q + 2'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_win_check_scheduler.sv
// Self-checking bench for win_check_scheduler.
// Board memory + window-walking reference model + per-cycle compare.
module tb_win_check_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pointer = 8'd0;
  logic [1:0] chess = 2'd0;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [1:0] rd_data = 2'd0;
  logic       busy;
  logic       done;
  logic       win;
  logic [1:0] win_dir;

  always #5 clk = ~clk;

  win_check_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pointer (pointer),
    .chess   (chess),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .win     (win),
    .win_dir (win_dir)
  );

  logic [1:0] board [256];

  always @(posedge clk)
    if (rd_en) rd_data <= board[rd_addr];

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  bit         active = 1'b0;
  bit         exp_en [64];
  logic [7:0] exp_addr [64];
  int         exp_done;
  bit         exp_win;
  logic [1:0] exp_dir;
  int         exp_len [4];

  int dr [4] = '{0, 1, 1, -1};
  int dc [4] = '{1, 0, 1, 1};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d, t=%0t)",
               name, act, req, cyc, $time);
    end
  endtask

  function automatic bit on_board(input int r, input int c);
    return r >= 0 && r < 16 && c >= 0 && c < 16;
  endfunction

  // Walk each line outward from the move, then slide a run counter over it.
  task automatic model(input logic [7:0] p, input logic [1:0] ch);
    int r0, c0, base, b, f, L, run, r, c, n;
    r0 = int'(p[7:4]);
    c0 = int'(p[3:0]);
    for (int i = 0; i < 64; i++) begin
      exp_en[i] = 1'b0;
      exp_addr[i] = 8'd0;
    end
    for (int d = 0; d < 4; d++) exp_len[d] = 0;
    exp_win = 1'b0;
    exp_dir = 2'd0;
    if (ch == 2'd0) begin
      exp_done = 1;
      return;
    end
    base = 1;
    for (int d = 0; d < 4; d++) begin
      b = 0;
      while (b < 4 && on_board(r0 - (b + 1) * dr[d], c0 - (b + 1) * dc[d])) b++;
      f = 0;
      while (f < 4 && on_board(r0 + (f + 1) * dr[d], c0 + (f + 1) * dc[d])) f++;
      L = b + f + 1;
      exp_len[d] = L;
      run = 0;
      for (int k = 0; k < L; k++) begin
        r = r0 + (k - b) * dr[d];
        c = c0 + (k - b) * dc[d];
        n = base + 1 + k;
        exp_en[n] = 1'b1;
        exp_addr[n] = 8'(r * 16 + c);
        if (board[r * 16 + c] == ch) run++;
        else run = 0;
        if (run >= 5) begin
          // the read issued in the hit cycle is still visible
          if (k + 1 < L) begin
            r = r0 + (k + 1 - b) * dr[d];
            c = c0 + (k + 1 - b) * dc[d];
            exp_en[n + 1] = 1'b1;
            exp_addr[n + 1] = 8'(r * 16 + c);
          end
          exp_win = 1'b1;
          exp_dir = 2'(d);
          exp_done = base + 3 + k;
          return;
        end
      end
      base += L + 2;
    end
    exp_done = base;
  endtask

  always @(negedge clk) begin
    if (active) begin
      check("busy", busy, (cyc >= 1 && cyc <= exp_done));
      check("done", done, (cyc == exp_done));
      check("rd_en", rd_en, (cyc < 64) ? exp_en[cyc] : 1'b0);
      if (cyc < 64 && exp_en[cyc] && rd_en)
        check("rd_addr", rd_addr, exp_addr[cyc]);
      if (cyc >= exp_done) begin
        check("win", win, exp_win);
        if (exp_win) check("win_dir", win_dir, exp_dir);
      end else if (cyc >= 1) begin
        check("win_clear", win, 1'b0);
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 256; i++) board[i] = 2'd0;
  endtask

  task automatic run_check(input logic [7:0] p, input logic [1:0] ch,
                           input bit pulse);
    int pc;
    model(p, ch);
    pc = (pulse && exp_done >= 4) ? int'($urandom_range(2, exp_done - 1)) : -1;
    @(posedge clk);
    #1;
    pointer = p;
    chess = ch;
    start = 1'b1;
    cyc = 0;
    active = 1'b1;
    for (int n = 1; n <= exp_done + 1; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      start = (n == pc);
      if (n == pc) begin
        pointer = 8'($urandom);
        chess = 2'($urandom_range(1, 2));
      end
    end
    @(negedge clk);
    #1;
    active = 1'b0;
    start = 1'b0;
  endtask

  task automatic plant_line(input logic [7:0] p, input logic [1:0] ch);
    int d, o, r, c;
    bit ok;
    d = int'($urandom_range(0, 3));
    o = int'($urandom_range(0, 4));
    ok = 1'b1;
    for (int k = 0; k < 5; k++)
      if (!on_board(int'(p[7:4]) + (k - o) * dr[d], int'(p[3:0]) + (k - o) * dc[d]))
        ok = 1'b0;
    if (ok)
      for (int k = 0; k < 5; k++) begin
        r = int'(p[7:4]) + (k - o) * dr[d];
        c = int'(p[3:0]) + (k - o) * dc[d];
        board[r * 16 + c] = ch;
      end
  endtask

  initial begin
    logic [7:0] p;
    logic [1:0] ch;
    clear_board();
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_win", win, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_win_dir", win_dir, 2'd0);
    check("rst_rd_addr", rd_addr, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // horizontal win
    clear_board();
    for (int c = 3; c <= 7; c++) board[8'h70 + c] = 2'd1;
    model(8'h75, 2'd1);
    check("model_h_done", exp_done, 10);
    check("model_h_win", exp_win, 1'b1);
    run_check(8'h75, 2'd1, 1'b0);

    // corner window
    clear_board();
    board[8'h00] = 2'd2;
    model(8'h00, 2'd2);
    check("model_c_len0", exp_len[0], 5);
    check("model_c_len3", exp_len[3], 1);
    check("model_c_done", exp_done, 25);
    run_check(8'h00, 2'd2, 1'b0);

    // anti-diagonal win
    clear_board();
    board[8'hA2] = 2'd2;
    board[8'h93] = 2'd2;
    board[8'h84] = 2'd2;
    board[8'h75] = 2'd2;
    board[8'h66] = 2'd2;
    model(8'h84, 2'd2);
    check("model_a_done", exp_done, 43);
    check("model_a_dir", exp_dir, 2'd3);
    run_check(8'h84, 2'd2, 1'b0);

    // broken run
    clear_board();
    for (int c = 0; c <= 3; c++) board[8'h50 + c] = 2'd1;
    board[8'h55] = 2'd1;
    model(8'h53, 2'd1);
    check("model_b_done", exp_done, 42);
    check("model_b_win", exp_win, 1'b0);
    run_check(8'h53, 2'd1, 1'b0);
    run_check(8'h53, 2'd1, 1'b1);

    // empty colour
    model(8'h53, 2'd0);
    check("model_z_done", exp_done, 1);
    run_check(8'h53, 2'd0, 1'b0);

    // reset mid-scan
    clear_board();
    for (int c = 3; c <= 7; c++) board[8'h70 + c] = 2'd1;
    model(8'h75, 2'd1);
    @(posedge clk);
    #1;
    pointer = 8'h75;
    chess = 2'd1;
    start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre_rst_rd_en", rd_en, exp_en[5]);
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rd_en", rd_en, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_win", win, 1'b0);
    check("mid_rst_rd_addr", rd_addr, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_check(8'h75, 2'd1, 1'b0);

    // randomized boards
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++)
        board[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      p = 8'($urandom);
      ch = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
      if (ch != 2'd0) begin
        board[p] = ch;
        if ($urandom_range(0, 1) == 1) plant_line(p, ch);
        else
          for (int k = 0; k < 6; k++)
            board[8'($urandom)] = ch;
      end
      run_check(p, ch, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/win_check_scheduler.md
WIN_CHECK_SCHEDULER -- requirements
Module: win_check_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and reset_n.
REQ-002 Port clk SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit: request a win check for the last move.
REQ-005 Port pointer SHALL be an input, 8 bits: last-move cell as {row[7:4], col[3:0]} on the 16x16 board.
REQ-006 Port chess SHALL be an input, 2 bits: colour of the player who moved; 0 = empty.
REQ-007 Port rd_en SHALL be an output, 1 bit: board-memory read strobe.
REQ-008 Port rd_addr SHALL be an output, 8 bits: board-memory read address.
REQ-009 Port rd_data SHALL be an input, 2 bits: cell contents, valid the cycle after rd_en.
REQ-010 Port busy SHALL be an output, 1 bit: check in progress.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-012 Port win SHALL be an output, 1 bit: five-or-more run found.
REQ-013 Port win_dir SHALL be an output, 2 bits: winning direction (0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal).

Function
REQ-014 The block SHALL accept start only in IDLE, latching pointer and chess; start SHALL be ignored while busy=1.
REQ-015 The FSM SHALL have states IDLE, SETUP, SCAN and DONE, with transitions IDLE->SETUP on accepted start, SETUP->SCAN, SCAN->SETUP (next direction), SCAN->DONE (win or direction 3 finished), and DONE->IDLE.
REQ-016 Directions SHALL be checked in order 0,1,2,3 using row/col steps (0,+1), (+1,0), (+1,+1) and (-1,+1).
REQ-017 In SETUP, back = min(4, distance to edge against the step) and fwd = min(4, distance to edge along the step), giving window length L = back+fwd+1 (range 1..9), with the first cell at pointer minus back steps.
REQ-018 rd_addr SHALL never leave the board: there is no 4-bit wrap of row or col.
REQ-019 In SCAN, the block SHALL issue one read per cycle for L consecutive cycles, then spend one extra cycle on the last compare, so each direction costs L+2 cycles including SETUP.
REQ-020 The run counter SHALL increment when rd_data==chess, clear otherwise, saturate at 5, and reset at each SETUP.
REQ-021 When the count reaches 5, the FSM SHALL go to DONE on the next edge, set win=1 and win_dir=current direction, and discard any in-flight read.
REQ-022 A check with no win SHALL assert done at cycle sum over d of (L_d+2), plus 1, counting the start cycle as cycle 0.
REQ-023 DONE SHALL last one cycle with done=1; win and win_dir SHALL hold until the next accepted start, which clears them.
REQ-024 A start with chess==0 SHALL go straight to DONE, with done at cycle 1, win=0 and no reads.
REQ-025 busy SHALL be 1 in SETUP, SCAN and DONE, and 0 in IDLE.

Reset
REQ-026 When reset_n=0, the block SHALL asynchronously force IDLE, with busy, done, win, rd_en = 0, win_dir=0, rd_addr=0, and counters cleared, including mid-scan.
REQ-027 After reset_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-028 Shared package win_check_pkg SHALL hold BOARD_DIM=16, MAX_REACH=4, WIN_LEN=5, the direction enum (DIR_H, DIR_V, DIR_D, DIR_A) and the FSM state enum.
REQ-029 The scheduler SHALL instantiate one sub-module, line_scan_unit, which owns the address stepping, rd_en, the run counter and the hit flag, and is reused for all four directions.

Verification
REQ-030 Horizontal win: cells 0x73..0x77 = 1, pointer 0x75, chess 1 -> win=1, win_dir=0, done at cycle 10.
REQ-031 Corner window: only 0x00 = 2, pointer 0x00, chess 2 -> window lengths 5,5,5,1; direction 3 reads only 0x00; done at cycle 25 with win=0.
REQ-032 Anti-diagonal win: cells 0xA2, 0x93, 0x84, 0x75, 0x66 = 2, pointer 0x84, chess 2 -> directions 0-2 run fully, then win=1 with win_dir=3.
REQ-033 Broken run: cells 0x50..0x53 and 0x55 = 1, pointer 0x53, chess 1 -> win=0, done at cycle 42.
REQ-034 Reset mid-scan: reset_n low at cycle 5 -> busy, rd_en, done and win go to 0 immediately; a new start after release completes correctly.
REQ-035 Degenerate and busy cases: start with chess=0 -> done at cycle 1, win=0, rd_en never set; start pulsed while busy -> no effect on the running check or its latency.
